// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the RV32I pipeline hazard controller: FSM state
// encoding, forwarding-select codes, the load opcode used by decode to build
// ex_is_load, and the producer/source match helper used by every compare.
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  // A producer feeds a source only if the source is really read, the producer
  // really writes, and the register is not x0 (x0 is hard-wired to zero).
  function automatic logic src_match(input logic       src_used,
                                     input logic       prod_we,
                                     input logic [4:0] prod_rd,
                                     input logic [4:0] src);
    return src_used && prod_we && (prod_rd == src) && (prod_rd != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
// Purely combinational compare block.
//   - EX operand forwarding selects (MEM beats WB, x0 never forwards).
//   - ID-source match flags against the EX and MEM producers, used by the
//     controller FSM for load-use and non-forwarding RAW stalls.
// Ports:
//   i_id_rs1/2, i_id_use_rs1/2 : ID sources and their use flags
//   i_ex_rs1/2                 : EX sources (operands being selected)
//   i_ex_rd/we, i_mem_rd/we,
//   i_wb_rd/we                 : producer destinations and write enables
//   o_fwd_a/b                  : operand selects (forced to FWD_REG if !EN_FWD)
//   o_id_ex_match              : an ID source matches the EX producer
//   o_id_mem_match             : an ID source matches the MEM producer
// -----------------------------------------------------------------------------
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter bit EN_FWD = 1'b1
) (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_ex_rs1,
  input  logic [4:0] i_ex_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_we,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_we,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_we,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic       o_id_ex_match,
  output logic       o_id_mem_match
);

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // EX-stage operands carry no use flag; an unused operand simply ignores
  // whatever select it receives.
  always_comb begin
    w_fwd_a = FWD_REG;
    if (src_match(1'b1, i_mem_we, i_mem_rd, i_ex_rs1)) begin
      w_fwd_a = FWD_MEM;
    end else if (src_match(1'b1, i_wb_we, i_wb_rd, i_ex_rs1)) begin
      w_fwd_a = FWD_WB;
    end
  end

  always_comb begin
    w_fwd_b = FWD_REG;
    if (src_match(1'b1, i_mem_we, i_mem_rd, i_ex_rs2)) begin
      w_fwd_b = FWD_MEM;
    end else if (src_match(1'b1, i_wb_we, i_wb_rd, i_ex_rs2)) begin
      w_fwd_b = FWD_WB;
    end
  end

  assign o_fwd_a = EN_FWD ? w_fwd_a : FWD_REG;
  assign o_fwd_b = EN_FWD ? w_fwd_b : FWD_REG;

  assign o_id_ex_match  = src_match(i_id_use_rs1, i_ex_we, i_ex_rd, i_id_rs1) ||
                          src_match(i_id_use_rs2, i_ex_we, i_ex_rd, i_id_rs2);

  assign o_id_mem_match = src_match(i_id_use_rs1, i_mem_we, i_mem_rd, i_id_rs1) ||
                          src_match(i_id_use_rs2, i_mem_we, i_mem_rd, i_id_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage RV32I core: multi-cycle load-use
// stalls, EX forwarding selects (or RAW stalls when forwarding is disabled),
// taken-branch flush, data-memory freeze, and saturating perf counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; detect load-use / RAW hazards
// LU_WAIT  | inserting the remaining load-use bubbles, r_cnt left to go
// MEM_WAIT | data memory busy; pipeline frozen, r_ret_state to resume
//
// Parameters:
//   LOAD_STALL : bubbles per load-use hazard (1..3)
//   EN_FWD     : 1 = forwarding selects driven, 0 = stall on EX/MEM RAW
//   CNT_W      : perf counter width
// Ports:
//   i_clk, i_rstn               : clock, async active-low reset
//   i_id_*, i_ex_*, i_mem_*,
//   i_wb_*                      : per-stage register ids and enables
//   i_br_taken                  : taken branch/jump resolved in EX
//   i_dmem_req, i_dmem_ready    : data-memory access in MEM / completion
//   o_pc_write, o_if_id_write   : PC and IF/ID enables
//   o_if_id_flush, o_id_ex_flush: bubble insertion
//   o_pipe_freeze               : hold ID/EX, EX/MEM, MEM/WB
//   o_fwd_a, o_fwd_b            : EX operand selects
//   o_stall_cnt, o_flush_cnt    : saturating perf counters
// All outputs are combinational from inputs and current state.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter bit EN_FWD     = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rs1,
  input  logic [4:0]       i_ex_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_we,
  input  logic             i_ex_is_load,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mem_we,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_wb_we,
  input  logic             i_br_taken,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_pipe_freeze,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  // Bubbles still owed after the detection cycle, which is itself a bubble.
  localparam logic [1:0]       LU_RELOAD = 2'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_t        r_state;
  hz_state_t        r_ret_state;
  logic [1:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  hz_state_t        w_nstate;
  hz_state_t        w_nret;
  hz_state_t        w_eff_state;
  logic [1:0]       w_ncnt;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_id_ex_match;
  logic             w_id_mem_match;
  logic             w_mem_busy;
  logic             w_lu;
  logic             w_raw;
  logic             w_pc_write;
  logic             w_if_id_write;
  logic             w_if_id_flush;
  logic             w_id_ex_flush;
  logic             w_freeze;
  logic             w_flush_evt;

  hazard_fwd_unit #(
    .EN_FWD (EN_FWD)
  ) u_fwd (
    .i_id_rs1       (i_id_rs1),
    .i_id_rs2       (i_id_rs2),
    .i_id_use_rs1   (i_id_use_rs1),
    .i_id_use_rs2   (i_id_use_rs2),
    .i_ex_rs1       (i_ex_rs1),
    .i_ex_rs2       (i_ex_rs2),
    .i_ex_rd        (i_ex_rd),
    .i_ex_we        (i_ex_we),
    .i_mem_rd       (i_mem_rd),
    .i_mem_we       (i_mem_we),
    .i_wb_rd        (i_wb_rd),
    .i_wb_we        (i_wb_we),
    .o_fwd_a        (w_fwd_a),
    .o_fwd_b        (w_fwd_b),
    .o_id_ex_match  (w_id_ex_match),
    .o_id_mem_match (w_id_mem_match)
  );

  assign w_mem_busy = i_dmem_req && !i_dmem_ready;
  assign w_lu       = i_ex_is_load && w_id_ex_match;
  // Write-first regfile: a WB producer is always visible to ID, never stalls.
  assign w_raw      = !EN_FWD && (w_id_ex_match || w_id_mem_match);

  // While frozen we behave, once memory completes, exactly like the state we
  // were frozen in; this lets the completion cycle do useful work at once.
  assign w_eff_state = (r_state == MEM_WAIT) ? r_ret_state : r_state;

  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_freeze      = 1'b0;
    w_flush_evt   = 1'b0;
    w_nstate      = w_eff_state;
    w_nret        = r_ret_state;
    w_ncnt        = r_cnt;

    if (w_mem_busy) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_freeze      = 1'b1;
      w_nstate      = MEM_WAIT;
      w_nret        = w_eff_state;
    end else if (i_br_taken) begin
      // The instruction behind the hazard is being squashed, so any owed
      // bubbles are moot.
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_flush_evt   = 1'b1;
      w_nstate      = RUN;
      w_ncnt        = 2'd0;
    end else if (w_eff_state == LU_WAIT) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
      if (r_cnt <= 2'd1) begin
        w_nstate = RUN;
        w_ncnt   = 2'd0;
      end else begin
        w_ncnt   = r_cnt - 2'd1;
      end
    end else if (w_lu) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
      w_ncnt        = LU_RELOAD;
      w_nstate      = (LU_RELOAD != 2'd0) ? LU_WAIT : RUN;
    end else if (w_raw) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= RUN;
      r_ret_state <= RUN;
      r_cnt       <= 2'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_nstate;
      r_ret_state <= w_nret;
      r_cnt       <= w_ncnt;
      if (!w_pc_write && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_flush_evt && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  // During reset the pipeline is held with bubbles and nothing advances.
  always_comb begin
    if (!i_rstn) begin
      o_pc_write    = 1'b0;
      o_if_id_write = 1'b0;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
      o_pipe_freeze = 1'b0;
      o_fwd_a       = FWD_REG;
      o_fwd_b       = FWD_REG;
    end else begin
      o_pc_write    = w_pc_write;
      o_if_id_write = w_if_id_write;
      o_if_id_flush = w_if_id_flush;
      o_id_ex_flush = w_id_ex_flush;
      o_pipe_freeze = w_freeze;
      o_fwd_a       = w_fwd_a;
      o_fwd_b       = w_fwd_b;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, freeze, fwd_a, fwd_b}
  localparam logic [8:0] E_RUN   = 9'b11000_00_00;
  localparam logic [8:0] E_STALL = 9'b00010_00_00;
  localparam logic [8:0] E_FLUSH = 9'b11110_00_00;
  localparam logic [8:0] E_FRZ   = 9'b00001_00_00;
  localparam logic [8:0] E_RST   = 9'b00110_00_00;
  localparam logic [8:0] A_MEM   = 9'b00000_10_00;
  localparam logic [8:0] A_WB    = 9'b00000_01_00;
  localparam logic [8:0] B_MEM   = 9'b00000_00_10;
  localparam logic [8:0] B_WB    = 9'b00000_00_01;

  typedef struct {
    int         inst;
    logic [8:0] exp;
    string      tag;
  } sb_t;

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_we, ex_is_load, mem_we, wb_we;
  logic       br_taken, dmem_req, dmem_ready;

  logic        o0_pcw, o0_ifw, o0_iff, o0_ief, o0_frz;
  logic [1:0]  o0_fa, o0_fb;
  logic [31:0] o0_sc, o0_fc;
  logic        o1_pcw, o1_ifw, o1_iff, o1_ief, o1_frz;
  logic [1:0]  o1_fa, o1_fb;
  logic [31:0] o1_sc, o1_fc;
  logic        o2_pcw, o2_ifw, o2_iff, o2_ief, o2_frz;
  logic [1:0]  o2_fa, o2_fb;
  logic [2:0]  o2_sc, o2_fc;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL(3), .EN_FWD(1'b1), .CNT_W(32)) u_dut0 (
    .i_clk(clk), .i_rstn(rstn),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd), .i_ex_we(ex_we), .i_ex_is_load(ex_is_load),
    .i_mem_rd(mem_rd), .i_mem_we(mem_we), .i_wb_rd(wb_rd), .i_wb_we(wb_we),
    .i_br_taken(br_taken), .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
    .o_pc_write(o0_pcw), .o_if_id_write(o0_ifw), .o_if_id_flush(o0_iff), .o_id_ex_flush(o0_ief),
    .o_pipe_freeze(o0_frz), .o_fwd_a(o0_fa), .o_fwd_b(o0_fb), .o_stall_cnt(o0_sc), .o_flush_cnt(o0_fc));

  hazard_ctrl #(.LOAD_STALL(1), .EN_FWD(1'b1), .CNT_W(32)) u_dut1 (
    .i_clk(clk), .i_rstn(rstn),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd), .i_ex_we(ex_we), .i_ex_is_load(ex_is_load),
    .i_mem_rd(mem_rd), .i_mem_we(mem_we), .i_wb_rd(wb_rd), .i_wb_we(wb_we),
    .i_br_taken(br_taken), .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
    .o_pc_write(o1_pcw), .o_if_id_write(o1_ifw), .o_if_id_flush(o1_iff), .o_id_ex_flush(o1_ief),
    .o_pipe_freeze(o1_frz), .o_fwd_a(o1_fa), .o_fwd_b(o1_fb), .o_stall_cnt(o1_sc), .o_flush_cnt(o1_fc));

  hazard_ctrl #(.LOAD_STALL(2), .EN_FWD(1'b0), .CNT_W(3)) u_dut2 (
    .i_clk(clk), .i_rstn(rstn),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd), .i_ex_we(ex_we), .i_ex_is_load(ex_is_load),
    .i_mem_rd(mem_rd), .i_mem_we(mem_we), .i_wb_rd(wb_rd), .i_wb_we(wb_we),
    .i_br_taken(br_taken), .i_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
    .o_pc_write(o2_pcw), .o_if_id_write(o2_ifw), .o_if_id_flush(o2_iff), .o_id_ex_flush(o2_ief),
    .o_pipe_freeze(o2_frz), .o_fwd_a(o2_fa), .o_fwd_b(o2_fb), .o_stall_cnt(o2_sc), .o_flush_cnt(o2_fc));

  function automatic logic [8:0] outs(input int k);
    case (k)
      0:       return {o0_pcw, o0_ifw, o0_iff, o0_ief, o0_frz, o0_fa, o0_fb};
      1:       return {o1_pcw, o1_ifw, o1_iff, o1_ief, o1_frz, o1_fa, o1_fb};
      default: return {o2_pcw, o2_ifw, o2_iff, o2_ief, o2_frz, o2_fa, o2_fb};
    endcase
  endfunction

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_we = 1'b0; ex_is_load = 1'b0;
    mem_rd = 5'd0; mem_we = 1'b0; wb_rd = 5'd0; wb_we = 1'b0;
    br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Load in EX writing x5, ID instruction reads x5 through rs1.
  task automatic set_lu_hazard();
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    sb_t e;
    @(posedge clk); #1;
    set_lu_hazard();
    mem_rd = 5'd7; mem_we = 1'b1; ex_rs1 = 5'd7; ex_rs2 = 5'd7;
    br_taken = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back('{k, E_RST, "reset_outs"});
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (outs(e.inst) !== e.exp) $display("FAIL %s inst%0d got=%b exp=%b", e.tag, e.inst, outs(e.inst), e.exp);
      else n_pass++;
    end
    n_chk++;
    if (o0_sc !== 32'd0 || o0_fc !== 32'd0) $display("FAIL reset_cnt got=%0d/%0d exp=0/0", o0_sc, o0_fc);
    else n_pass++;
  endtask

  task automatic test_lu_single();
    sb_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      case (i)
        0: begin set_lu_hazard(); sb.push_back('{1, E_STALL, "lu1_bubble"}); end
        1: begin mem_rd = 5'd5; mem_we = 1'b1; ex_rs1 = 5'd5; sb.push_back('{1, E_RUN | A_MEM, "lu1_fwd"}); end
        default: sb.push_back('{1, E_RUN, "lu1_idle"});
      endcase
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (outs(e.inst) !== e.exp) $display("FAIL %s[%0d] got=%b exp=%b", e.tag, i, outs(e.inst), e.exp);
      else n_pass++;
    end
    n_chk++;
    if (o1_sc !== 32'd1) $display("FAIL lu1_stall_cnt got=%0d exp=1", o1_sc);
    else n_pass++;
  endtask

  task automatic test_lu_three();
    sb_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      case (i)
        0: begin set_lu_hazard(); sb.push_back('{0, E_STALL, "lu3_b0"}); end
        1: begin id_rs1 = 5'd5; id_use_rs1 = 1'b1; mem_rd = 5'd5; mem_we = 1'b1; sb.push_back('{0, E_STALL, "lu3_b1"}); end
        2: begin id_rs1 = 5'd5; id_use_rs1 = 1'b1; wb_rd = 5'd5; wb_we = 1'b1; sb.push_back('{0, E_STALL, "lu3_b2"}); end
        3: begin ex_rs1 = 5'd5; sb.push_back('{0, E_RUN, "lu3_resume"}); end
        default: begin ex_rs1 = 5'd9; wb_rd = 5'd9; wb_we = 1'b1; sb.push_back('{0, E_RUN | A_WB, "lu3_wbfwd"}); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (outs(e.inst) !== e.exp) $display("FAIL %s got=%b exp=%b", e.tag, outs(e.inst), e.exp);
      else n_pass++;
      if (i == 0) begin
        n_chk++;
        if (o0_sc !== 32'd0) $display("FAIL lu3_cnt_start got=%0d exp=0", o0_sc);
        else n_pass++;
      end
    end
    n_chk++;
    if (o0_sc !== 32'd3) $display("FAIL lu3_stall_cnt got=%0d exp=3", o0_sc);
    else n_pass++;
  endtask

  task automatic test_no_hazard_edges();
    sb_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      case (i)
        0: begin ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; end
        1: begin set_lu_hazard(); id_use_rs1 = 1'b0; end
        default: begin set_lu_hazard(); ex_we = 1'b0; end
      endcase
      sb.push_back('{0, E_RUN, "no_hazard"});
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (outs(e.inst) !== e.exp) $display("FAIL %s[%0d] got=%b exp=%b", e.tag, i, outs(e.inst), e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_fwd_priority();
    sb_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      case (i)
        0: begin
          mem_rd = 5'd7; mem_we = 1'b1; wb_rd = 5'd7; wb_we = 1'b1; ex_rs2 = 5'd7;
          sb.push_back('{0, E_RUN | B_MEM, "fwd_mem_over_wb"});
        end
        1: begin
          mem_rd = 5'd0; mem_we = 1'b1; wb_rd = 5'd0; wb_we = 1'b1; ex_rs2 = 5'd0;
          sb.push_back('{0, E_RUN, "fwd_x0"});
        end
        2: begin
          mem_rd = 5'd7; mem_we = 1'b0; wb_rd = 5'd7; wb_we = 1'b1; ex_rs1 = 5'd7; ex_rs2 = 5'd7;
          sb.push_back('{0, E_RUN | A_WB | B_WB, "fwd_wb_only"});
        end
        default: begin
          mem_rd = 5'd7; mem_we = 1'b1; wb_rd = 5'd9; wb_we = 1'b1; ex_rs1 = 5'd9; ex_rs2 = 5'd7;
          sb.push_back('{0, E_RUN | A_WB | B_MEM, "fwd_split"});
        end
      endcase
      sb.push_back('{2, E_RUN, "nofwd_sel_zero"});
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_chk++;
        if (outs(e.inst) !== e.exp) $display("FAIL %s inst%0d got=%b exp=%b", e.tag, e.inst, outs(e.inst), e.exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_branch_vs_lu();
    sb_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      case (i)
        0: begin set_lu_hazard(); br_taken = 1'b1; sb.push_back('{0, E_FLUSH, "br_beats_lu"}); end
        1: sb.push_back('{0, E_RUN, "br_no_stall"});
        2: begin set_lu_hazard(); sb.push_back('{0, E_STALL, "br_lu_start"}); end
        3: begin br_taken = 1'b1; sb.push_back('{0, E_FLUSH, "br_in_luwait"}); end
        default: sb.push_back('{0, E_RUN, "br_luwait_exit"});
      endcase
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (outs(e.inst) !== e.exp) $display("FAIL %s got=%b exp=%b", e.tag, outs(e.inst), e.exp);
      else n_pass++;
      if (i == 1) begin
        n_chk++;
        if (o0_fc !== 32'd1 || o0_sc !== 32'd0) $display("FAIL br_cnts got=%0d/%0d exp=1/0", o0_fc, o0_sc);
        else n_pass++;
      end
    end
    n_chk++;
    if (o0_fc !== 32'd2 || o0_sc !== 32'd1) $display("FAIL br_cnts_end got=%0d/%0d exp=2/1", o0_fc, o0_sc);
    else n_pass++;
  endtask

  task automatic test_mem_freeze();
    sb_t e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (i == 0) begin
        set_lu_hazard();
        sb.push_back('{0, E_STALL, "frz_lu_start"});
      end else if (i <= 4) begin
        dmem_req = 1'b1;
        sb.push_back('{0, E_FRZ, "frz_hold"});
      end else if (i <= 6) begin
        dmem_req = (i == 5);
        dmem_ready = (i == 5);
        sb.push_back('{0, E_STALL, "frz_bubbles_left"});
      end else if (i == 7) begin
        sb.push_back('{0, E_RUN, "frz_resume"});
      end else begin
        dmem_req = 1'b1; dmem_ready = 1'b1;
        sb.push_back('{0, E_RUN, "frz_zero_wait"});
      end
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (outs(e.inst) !== e.exp) $display("FAIL %s[%0d] got=%b exp=%b", e.tag, i, outs(e.inst), e.exp);
      else n_pass++;
    end
    n_chk++;
    if (o0_sc !== 32'd7) $display("FAIL frz_stall_cnt got=%0d exp=7", o0_sc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    sb_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      case (i)
        0: begin set_lu_hazard(); sb.push_back('{0, E_STALL, "rms_start"}); end
        1: begin rstn = 1'b0; sb.push_back('{0, E_RST, "rms_in_reset"}); end
        default: begin rstn = 1'b1; sb.push_back('{0, E_RUN, "rms_back_run"}); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (outs(e.inst) !== e.exp) $display("FAIL %s got=%b exp=%b", e.tag, outs(e.inst), e.exp);
      else n_pass++;
      if (i == 1) begin
        n_chk++;
        if (o0_sc !== 32'd0) $display("FAIL rms_cnt got=%0d exp=0", o0_sc);
        else n_pass++;
      end
    end
  endtask

  task automatic test_raw_nofwd();
    sb_t e;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      clear_inputs();
      id_rs2 = 5'd3; id_use_rs2 = 1'b1;
      if (i == 0) begin
        ex_rd = 5'd3; ex_we = 1'b1;
        sb.push_back('{2, E_STALL, "raw_ex"});
      end else if (i == 1) begin
        mem_rd = 5'd3; mem_we = 1'b1;
        sb.push_back('{2, E_STALL, "raw_mem"});
      end else if (i == 2) begin
        wb_rd = 5'd3; wb_we = 1'b1;
        sb.push_back('{2, E_RUN, "raw_wb_free"});
      end else if (i < 12) begin
        mem_rd = 5'd3; mem_we = 1'b1;
        sb.push_back('{2, E_STALL, "raw_sat_fill"});
      end else begin
        sb.push_back('{2, E_RUN, "raw_clear"});
      end
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (outs(e.inst) !== e.exp) $display("FAIL %s[%0d] got=%b exp=%b", e.tag, i, outs(e.inst), e.exp);
      else n_pass++;
      if (i == 2) begin
        n_chk++;
        if (o2_sc !== 3'd2) $display("FAIL raw_stall_cnt got=%0d exp=2", o2_sc);
        else n_pass++;
      end
    end
    n_chk++;
    if (o2_sc !== 3'd7) $display("FAIL raw_stall_sat got=%0d exp=7", o2_sc);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_lu_single();
    test_lu_three();
    test_no_hazard_edges();
    test_fwd_priority();
    test_branch_vs_lu();
    test_mem_freeze();
    test_reset_mid_stall();
    test_raw_nofwd();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage RV32I core. It sits beside the IF/ID/EX/MEM/WB registers and replaces the single-bubble load-use detector. It adds:
- multi-cycle load-use stalls;
- optional EX forwarding select, with a stall fallback when forwarding is disabled;
- taken-branch/jump flush;
- a freeze handshake for variable-latency data memory;
- saturating stall and flush performance counters.

## Interface
- LOAD_STALL, 1: bubbles inserted on a load-use hazard (1..3).
- EN_FWD, 1: 1 drives forwarding selects; 0 holds selects at 0 and stalls on every RAW hazard against EX/MEM producers.
- CNT_W, 32: width of the performance counters.
- clk  in  1  system clock.
- rstn  in  1  reset; one clock; asynchronous, active-low.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX.
- ex_rd, ex_we, ex_is_load  in  5/1/1  EX destination, register write enable, and opcode==0000011.
- mem_rd, mem_we  in  5/1  MEM destination and write enable.
- wb_rd, wb_we  in  5/1  WB destination and write enable.
- br_taken  in  1  taken branch or jump resolved in EX.
- dmem_req, dmem_ready  in  1 each  data-memory access in MEM / completion.
- pc_write, if_id_write  out  1 each  PC and IF/ID register enables.
- if_id_flush, id_ex_flush  out  1 each  insert a bubble (zero control).
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 WB, 10 MEM.
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters.

## Operation
- Register x0 never matches any hazard or forwarding compare.
- A source "matches" a producer when:
  - the use flag is set,
  - the producer write enable is 1,
  - rd == rs,
  - rd != 0.
- **Forwarding (EN_FWD=1)**
  - fwd_a selects 10 if the MEM producer matches ex_rs1; else 01 if the WB producer matches; else 00.
  - fwd_b follows the same rule using ex_rs2.
  - MEM takes priority over WB.
- **Load-use hazard (lu)**: ex_is_load is set and the EX producer matches either ID source.
- **Non-forwarding RAW (EN_FWD=0)**: raw is set when the EX or MEM producer matches either ID source. The register file is write-first, so WB producers never stall.
- **FSM states**: RUN, LU_WAIT, MEM_WAIT.
  - Priority 1: if dmem_req && !dmem_ready in any state, the output is freeze: pipe_freeze=1, pc_write=0, if_id_write=0, no flushes. Enter MEM_WAIT, keeping the remaining-bubble count. Return to the saved state when dmem_ready rises.
  - Priority 2: if br_taken, assert if_id_flush=1 and id_ex_flush=1 with pc_write=1, and any pending lu/raw is discarded. From LU_WAIT, return to RUN.
  - Priority 3: in RUN with lu (or raw when EN_FWD=0), stall: pc_write=0, if_id_write=0, id_ex_flush=1.
    - For lu, load cnt with LOAD_STALL-1 and go to LU_WAIT if cnt>0.
    - For raw, re-evaluate every cycle.
  - LU_WAIT: stall every cycle and decrement cnt; return to RUN when cnt reaches 1. Total bubbles equal LOAD_STALL.
  - Otherwise all enables are 1 and all flushes are 0.
- **stall_cnt** increments on every cycle with pc_write=0 (freeze and stall).
- **flush_cnt** increments on every br_taken flush.
- Both counters saturate at all-ones.

## Timing
- All outputs are combinational from the inputs, state, and cnt in the same cycle.
- State, cnt, and the counters update on posedge clk.
- While rstn=0, outputs are forced:
  - pc_write=0, if_id_write=0;
  - if_id_flush=1, id_ex_flush=1;
  - pipe_freeze=0;
  - fwd_a=fwd_b=00.
- Reset values: state RUN, cnt=0, stall_cnt=flush_cnt=0.
- Reset asserted mid-stall returns the FSM to RUN immediately; no bubble count survives.
- Load-use penalty is exactly LOAD_STALL cycles. With LOAD_STALL=1 the controller never leaves RUN.
- If dmem_ready is already 1 in the cycle dmem_req rises, there is zero freeze.
- Simultaneous lu and br_taken: flush wins, with 0 stall cycles.

## Structure
- Shared package hazard_pkg holds:
  - the state enum {RUN, LU_WAIT, MEM_WAIT};
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - OPC_LOAD=7'b0000011 for the decode stage that drives ex_is_load.
- One combinational sub-module, hazard_fwd_unit, computes fwd_a/fwd_b and the match flags.
- The FSM and the counters live in hazard_ctrl.

## Test plan
- **Load-use, single bubble**: LOAD_STALL=1, ex_is_load=1, ex_rd=5, id_rs1=5 with use -> one cycle of pc_write=0, id_ex_flush=1, then fwd_a=10 the next cycle.
- **Load-use, three bubbles**: LOAD_STALL=3, same hazard -> exactly 3 stall cycles; stall_cnt goes 0->3.
- **Forwarding priority**: mem_rd=wb_rd=7, both we=1, ex_rs2=7 -> fwd_b=10. Then with rd=0 on both -> fwd_b=00.
- **Branch beats load-use**: br_taken=1 together with an lu hazard -> if_id_flush=id_ex_flush=1, pc_write=1, flush_cnt=1, no stall.
- **Memory freeze during LU_WAIT**: dmem_req=1 held with dmem_ready=0 for 4 cycles -> pipe_freeze=1 for 4 cycles, then the remaining bubbles complete.
- **Reset mid-stall and EN_FWD=0**: rstn low during LU_WAIT -> RUN, counters 0. With EN_FWD=0, MEM producer rd=3 and id_rs2=3 -> stall until the producer reaches WB.
